// File: rtl/usb2_ep_pkg.sv
// Shared endpoint codes for the USB 2.0 endpoint ring and the protocol layer.
// Transfer-type and data PID encodings plus the isochronous sequencing helper.
package usb2_ep_pkg;

   localparam int unsigned MODE_W = 2;
   localparam int unsigned PID_W  = 2;

   typedef enum logic [MODE_W-1:0] {
      EP_MODE_CONTROL   = 2'd0,
      EP_MODE_ISOCH     = 2'd1,
      EP_MODE_BULK      = 2'd2,
      EP_MODE_INTERRUPT = 2'd3
   } ep_mode_e;

   typedef enum logic [PID_W-1:0] {
      DATA_TOGGLE_0 = 2'd0,
      DATA_TOGGLE_1 = 2'd1,
      DATA_TOGGLE_2 = 2'd2,
      DATA_TOGGLE_M = 2'd3
   } data_pid_e;

   // First PID of a high-bandwidth isochronous microframe; mult 0 behaves as 1.
   function automatic logic [PID_W-1:0] iso_first_pid(input logic [1:0] mult);
      logic [PID_W-1:0] pid;
      if (mult == 2'd0) begin
         pid = PID_W'(0);
      end else begin
         pid = PID_W'(mult - 2'd1);
      end
      return pid;
   endfunction

endpackage

// File: rtl/usb2_ep_ram.sv
// Single-clock simple dual-port byte RAM with a registered read port.
// Read-during-write to the same address returns the previous contents.
module usb2_ep_ram #(
   parameter int unsigned AW = 11
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [7:0] mem_q [DEPTH];
   logic [7:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      rdata_q <= mem_q[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/usb2_ep_ring.sv
// USB 2.0 endpoint buffer: N-slot ring of packet buffers with per-slot committed
// length, commit/arm handshakes and data-toggle / PID sequencing.
module usb2_ep_ring
   import usb2_ep_pkg::*;
#(
   parameter int unsigned NUM_BUF = 4,
   parameter int unsigned BUF_AW  = 9,
   parameter int unsigned LEN_W   = 10,
   parameter int unsigned CNT_W   = $clog2(NUM_BUF + 1)
) (
   input  logic              phy_clk,
   input  logic              reset_n,
   input  logic [BUF_AW-1:0] buf_in_addr,
   input  logic [7:0]        buf_in_data,
   input  logic              buf_in_wren,
   output logic              buf_in_ready,
   input  logic              buf_in_commit,
   input  logic [LEN_W-1:0]  buf_in_commit_len,
   output logic              buf_in_commit_ack,
   output logic              buf_in_overflow,
   input  logic [BUF_AW-1:0] buf_out_addr,
   output logic [7:0]        buf_out_q,
   output logic [LEN_W-1:0]  buf_out_len,
   output logic              buf_out_hasdata,
   output logic [CNT_W-1:0]  buf_out_count,
   input  logic              buf_out_arm,
   output logic              buf_out_arm_ack,
   output logic              buf_out_underflow,
   input  logic [1:0]        mode,
   input  logic [1:0]        iso_mult,
   input  logic              data_toggle_act,
   input  logic              data_toggle_clear,
   output logic [1:0]        data_toggle
);

   localparam int unsigned PTR_W  = $clog2(NUM_BUF);
   localparam int unsigned RAM_AW = PTR_W + BUF_AW;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [LEN_W-1:0] len_q [NUM_BUF];
   logic [LEN_W-1:0] len_out_q, len_out_d;
   logic             ready_q, ready_d;
   logic             hasdata_q, hasdata_d;
   logic             commit_ack_q, commit_ack_d;
   logic             overflow_q, overflow_d;
   logic             arm_ack_q, arm_ack_d;
   logic             underflow_q, underflow_d;
   logic [1:0]       toggle_q, toggle_d;

   logic             commit_ok_c;
   logic             arm_ok_c;
   logic             full_c;
   logic             ram_we_c;
   logic [1:0]       iso_first_c;

   // Accept decisions use the pre-edge occupancy only.
   always_comb begin
      full_c      = (count_q == CNT_W'(NUM_BUF));
      commit_ok_c = buf_in_commit && !full_c;
      arm_ok_c    = buf_out_arm && (count_q != '0);
      ram_we_c    = buf_in_wren && reset_n && !full_c;
   end

   // Pointer, occupancy and handshake next-state logic.
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      commit_ack_d = commit_ok_c;
      overflow_d   = buf_in_commit && !commit_ok_c;
      arm_ack_d    = arm_ok_c;
      underflow_d  = buf_out_arm && !arm_ok_c;
      if (commit_ok_c) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (arm_ok_c) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (commit_ok_c && !arm_ok_c) begin
         count_d = count_q + CNT_W'(1);
      end else if (arm_ok_c && !commit_ok_c) begin
         count_d = count_q - CNT_W'(1);
      end
      ready_d   = (count_d < CNT_W'(NUM_BUF));
      hasdata_d = (count_d != '0);
      // An empty ring keeps presenting the last length it showed.
      len_out_d = (count_q != '0) ? len_q[rd_ptr_q] : len_out_q;
   end

   // Data toggle: clear beats act; isochronous counts down from mult-1.
   always_comb begin
      iso_first_c = iso_first_pid(iso_mult);
      toggle_d    = toggle_q;
      if (data_toggle_clear) begin
         toggle_d = (mode == EP_MODE_ISOCH) ? iso_first_c : DATA_TOGGLE_0;
      end else if (data_toggle_act) begin
         if (mode == EP_MODE_ISOCH) begin
            if ((toggle_q == DATA_TOGGLE_0) || (toggle_q > iso_first_c)) begin
               toggle_d = iso_first_c;
            end else begin
               toggle_d = toggle_q - 2'd1;
            end
         end else begin
            toggle_d = (toggle_q == DATA_TOGGLE_0) ? DATA_TOGGLE_1 : DATA_TOGGLE_0;
         end
      end
   end

   always_ff @(posedge phy_clk) begin
      if (!reset_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         len_out_q    <= '0;
         ready_q      <= 1'b1;
         hasdata_q    <= 1'b0;
         commit_ack_q <= 1'b0;
         overflow_q   <= 1'b0;
         arm_ack_q    <= 1'b0;
         underflow_q  <= 1'b0;
         toggle_q     <= DATA_TOGGLE_0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         len_out_q    <= len_out_d;
         ready_q      <= ready_d;
         hasdata_q    <= hasdata_d;
         commit_ack_q <= commit_ack_d;
         overflow_q   <= overflow_d;
         arm_ack_q    <= arm_ack_d;
         underflow_q  <= underflow_d;
         toggle_q     <= toggle_d;
      end
   end

   // Lengths are stored as given; oversize values are the producer's concern.
   always_ff @(posedge phy_clk) begin
      if (reset_n && commit_ok_c) begin
         len_q[wr_ptr_q] <= buf_in_commit_len;
      end
   end

   usb2_ep_ram #(
      .AW (RAM_AW)
   ) u_ram (
      .clk   (phy_clk),
      .we    (ram_we_c),
      .waddr ({wr_ptr_q, buf_in_addr}),
      .wdata (buf_in_data),
      .raddr ({rd_ptr_q, buf_out_addr}),
      .rdata (buf_out_q)
   );

   assign buf_in_ready      = ready_q;
   assign buf_in_commit_ack = commit_ack_q;
   assign buf_in_overflow   = overflow_q;
   assign buf_out_len       = len_out_q;
   assign buf_out_hasdata   = hasdata_q;
   assign buf_out_count     = count_q;
   assign buf_out_arm_ack   = arm_ack_q;
   assign buf_out_underflow = underflow_q;
   assign data_toggle       = toggle_q;

endmodule

// File: tb/tb_usb2_ep_ring.sv
// Directed self-checking bench for usb2_ep_ring with a scoreboard queue for
// read data, lengths and toggle sequences.
module tb_usb2_ep_ring;
   import usb2_ep_pkg::*;

   localparam int unsigned NUM_BUF = 4;
   localparam int unsigned BUF_AW  = 9;
   localparam int unsigned LEN_W   = 10;
   localparam int unsigned CNT_W   = 3;

   logic              phy_clk = 1'b0;
   logic              reset_n;
   logic [BUF_AW-1:0] buf_in_addr;
   logic [7:0]        buf_in_data;
   logic              buf_in_wren;
   logic              buf_in_ready;
   logic              buf_in_commit;
   logic [LEN_W-1:0]  buf_in_commit_len;
   logic              buf_in_commit_ack;
   logic              buf_in_overflow;
   logic [BUF_AW-1:0] buf_out_addr;
   logic [7:0]        buf_out_q;
   logic [LEN_W-1:0]  buf_out_len;
   logic              buf_out_hasdata;
   logic [CNT_W-1:0]  buf_out_count;
   logic              buf_out_arm;
   logic              buf_out_arm_ack;
   logic              buf_out_underflow;
   logic [1:0]        mode;
   logic [1:0]        iso_mult;
   logic              data_toggle_act;
   logic              data_toggle_clear;
   logic [1:0]        data_toggle;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [31:0] sb_q [$];

   always #5 phy_clk = ~phy_clk;

   usb2_ep_ring #(
      .NUM_BUF (NUM_BUF),
      .BUF_AW  (BUF_AW),
      .LEN_W   (LEN_W),
      .CNT_W   (CNT_W)
   ) dut (
      .phy_clk           (phy_clk),
      .reset_n           (reset_n),
      .buf_in_addr       (buf_in_addr),
      .buf_in_data       (buf_in_data),
      .buf_in_wren       (buf_in_wren),
      .buf_in_ready      (buf_in_ready),
      .buf_in_commit     (buf_in_commit),
      .buf_in_commit_len (buf_in_commit_len),
      .buf_in_commit_ack (buf_in_commit_ack),
      .buf_in_overflow   (buf_in_overflow),
      .buf_out_addr      (buf_out_addr),
      .buf_out_q         (buf_out_q),
      .buf_out_len       (buf_out_len),
      .buf_out_hasdata   (buf_out_hasdata),
      .buf_out_count     (buf_out_count),
      .buf_out_arm       (buf_out_arm),
      .buf_out_arm_ack   (buf_out_arm_ack),
      .buf_out_underflow (buf_out_underflow),
      .mode              (mode),
      .iso_mult          (iso_mult),
      .data_toggle_act   (data_toggle_act),
      .data_toggle_clear (data_toggle_clear),
      .data_toggle       (data_toggle)
   );

   task automatic tick();
      @(posedge phy_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sb_chk(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s observed=%0h expected=<none queued>", tag, obs);
      end else begin
         e = sb_q.pop_front();
         chk(tag, obs, e);
      end
   endtask

   task automatic pulse(input logic c, input logic [LEN_W-1:0] len, input logic a);
      buf_in_commit     = c;
      buf_in_commit_len = len;
      buf_out_arm       = a;
      tick();
      buf_in_commit = 1'b0;
      buf_out_arm   = 1'b0;
   endtask

   task automatic hs_chk(input string tag, input logic cack, input logic ovf,
                         input logic aack, input logic udf, input int unsigned cnt);
      chk({tag, "_cack"}, 32'(buf_in_commit_ack), 32'(cack));
      chk({tag, "_ovf"},  32'(buf_in_overflow),   32'(ovf));
      chk({tag, "_aack"}, 32'(buf_out_arm_ack),   32'(aack));
      chk({tag, "_udf"},  32'(buf_out_underflow), 32'(udf));
      chk({tag, "_cnt"},  32'(buf_out_count),     32'(cnt));
   endtask

   task automatic tog(input logic clr, input logic act);
      data_toggle_clear = clr;
      data_toggle_act   = act;
      tick();
      data_toggle_clear = 1'b0;
      data_toggle_act   = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      buf_in_addr = '0; buf_in_data = '0; buf_in_wren = 1'b0;
      buf_in_commit = 1'b0; buf_in_commit_len = '0;
      buf_out_addr = '0; buf_out_arm = 1'b0;
      mode = EP_MODE_BULK; iso_mult = 2'd0;
      data_toggle_act = 1'b0; data_toggle_clear = 1'b0;
      tick(); tick();
      reset_n = 1'b1;
      tick();
      chk("rst_ready",   32'(buf_in_ready),    32'd1);
      chk("rst_hasdata", 32'(buf_out_hasdata), 32'd0);
      chk("rst_count",   32'(buf_out_count),   32'd0);
      chk("rst_len",     32'(buf_out_len),     32'd0);
      chk("rst_toggle",  32'(data_toggle),     32'd0);
      hs_chk("rst", 1'b0, 1'b0, 1'b0, 1'b0, 0);

      // Arm on an empty ring.
      pulse(1'b0, '0, 1'b1);
      hs_chk("udf", 1'b0, 1'b0, 1'b0, 1'b1, 0);
      tick();
      chk("udf_clr", 32'(buf_out_underflow), 32'd0);

      // Slot 0 payload and commit.
      for (int k = 0; k < 64; k++) begin
         buf_in_wren = 1'b1;
         buf_in_addr = BUF_AW'(k);
         buf_in_data = 8'(k) ^ 8'hA5;
         tick();
      end
      buf_in_wren = 1'b0;
      pulse(1'b1, 10'd64, 1'b0);
      hs_chk("c0", 1'b1, 1'b0, 1'b0, 1'b0, 1);
      chk("c0_hasdata", 32'(buf_out_hasdata), 32'd1);
      tick();
      chk("c0_ack_clr", 32'(buf_in_commit_ack), 32'd0);
      chk("c0_len", 32'(buf_out_len), 32'd64);
      for (int k = 0; k < 64; k++) begin
         buf_out_addr = BUF_AW'(k);
         sb_q.push_back(32'(8'(k) ^ 8'hA5));
         tick();
         sb_chk("rd_data", 32'(buf_out_q));
      end

      // Fill to full, then overflow.
      for (int i = 1; i < 4; i++) begin
         pulse(1'b1, LEN_W'(64 + i), 1'b0);
         hs_chk("fill", 1'b1, 1'b0, 1'b0, 1'b0, 1 + i);
         chk("fill_ready", 32'(buf_in_ready), (i == 3) ? 32'd0 : 32'd1);
      end
      pulse(1'b1, 10'd99, 1'b0);
      hs_chk("ovf", 1'b0, 1'b1, 1'b0, 1'b0, 4);

      // A write while full must not land in slot 0.
      buf_in_wren = 1'b1; buf_in_addr = '0; buf_in_data = 8'hFF;
      tick();
      buf_in_wren = 1'b0;
      buf_out_addr = '0;
      sb_q.push_back(32'h0000_00A5);
      tick();
      sb_chk("full_wren", 32'(buf_out_q));

      // Full ring rejects commit even with a simultaneous arm.
      pulse(1'b1, 10'd77, 1'b1);
      hs_chk("full_ca", 1'b0, 1'b1, 1'b1, 1'b0, 3);
      tick();
      chk("len_s1", 32'(buf_out_len), 32'd65);
      pulse(1'b0, '0, 1'b1);
      hs_chk("arm2", 1'b0, 1'b0, 1'b1, 1'b0, 2);
      tick();
      chk("len_s2", 32'(buf_out_len), 32'd66);
      pulse(1'b0, '0, 1'b1);
      hs_chk("arm3", 1'b0, 1'b0, 1'b1, 1'b0, 1);
      tick();
      chk("len_s3", 32'(buf_out_len), 32'd67);
      pulse(1'b1, 10'd68, 1'b0);
      hs_chk("c68", 1'b1, 1'b0, 1'b0, 1'b0, 2);
      pulse(1'b1, 10'd69, 1'b1);
      hs_chk("both", 1'b1, 1'b0, 1'b1, 1'b0, 2);
      tick();
      chk("len_both", 32'(buf_out_len), 32'd68);
      pulse(1'b0, '0, 1'b1);
      pulse(1'b0, '0, 1'b1);
      hs_chk("drain", 1'b0, 1'b0, 1'b1, 1'b0, 0);
      tick(); tick();
      chk("drain_hasdata", 32'(buf_out_hasdata), 32'd0);
      chk("drain_ready",   32'(buf_in_ready),    32'd1);
      chk("drain_stale",   32'(buf_out_len),     32'd69);

      // Wrap through the ring several times.
      for (int i = 0; i < 10; i++) begin
         sb_q.push_back(32'(i));
         pulse(1'b1, LEN_W'(i), 1'b0);
         tick();
         sb_chk("wrap_len", 32'(buf_out_len));
         pulse(1'b0, '0, 1'b1);
      end
      chk("wrap_count", 32'(buf_out_count), 32'd0);

      // Bulk toggle: 0,1,0,1.
      mode = EP_MODE_BULK;
      sb_q.push_back(32'd0); sb_q.push_back(32'd1); sb_q.push_back(32'd0); sb_q.push_back(32'd1);
      tog(1'b1, 1'b0);
      sb_chk("bulk_tog", 32'(data_toggle));
      for (int i = 0; i < 3; i++) begin
         tog(1'b0, 1'b1);
         sb_chk("bulk_tog", 32'(data_toggle));
      end
      // Isochronous mult 3: 2,1,0,2.
      mode = EP_MODE_ISOCH; iso_mult = 2'd3;
      sb_q.push_back(32'd2); sb_q.push_back(32'd1); sb_q.push_back(32'd0); sb_q.push_back(32'd2);
      tog(1'b1, 1'b0);
      sb_chk("iso3_tog", 32'(data_toggle));
      for (int i = 0; i < 3; i++) begin
         tog(1'b0, 1'b1);
         sb_chk("iso3_tog", 32'(data_toggle));
      end
      // Clear beats act; then a smaller mult reloads on act.
      tog(1'b1, 1'b1);
      chk("clr_prio", 32'(data_toggle), 32'd2);
      iso_mult = 2'd2;
      tog(1'b0, 1'b1);
      chk("mult_shrink", 32'(data_toggle), 32'd1);
      iso_mult = 2'd0;
      tog(1'b1, 1'b0);
      chk("iso0_clr", 32'(data_toggle), 32'd0);
      tog(1'b0, 1'b1);
      chk("iso0_act", 32'(data_toggle), 32'd0);

      // Reset with three slots committed and a write in flight.
      mode = EP_MODE_BULK;
      tog(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) pulse(1'b1, LEN_W'(20 + i), 1'b0);
      chk("pre_rst_count", 32'(buf_out_count), 32'd3);
      buf_in_wren = 1'b1; buf_in_addr = BUF_AW'(5); buf_in_data = 8'h5A;
      reset_n = 1'b0;
      tick();
      chk("mrst_count",   32'(buf_out_count),   32'd0);
      chk("mrst_hasdata", 32'(buf_out_hasdata), 32'd0);
      chk("mrst_ready",   32'(buf_in_ready),    32'd1);
      chk("mrst_toggle",  32'(data_toggle),     32'd0);
      chk("mrst_len",     32'(buf_out_len),     32'd0);
      tick();
      buf_in_wren = 1'b0;
      reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         buf_in_wren = 1'b1;
         buf_in_addr = BUF_AW'(k);
         buf_in_data = 8'(k) + 8'h10;
         tick();
      end
      buf_in_wren = 1'b0;
      pulse(1'b1, 10'd4, 1'b0);
      hs_chk("post_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1);
      for (int k = 0; k < 6; k++) begin
         buf_out_addr = BUF_AW'(k);
         sb_q.push_back((k < 4) ? 32'(k + 16) : 32'(8'(k) ^ 8'hA5));
         tick();
         sb_chk("post_rst_rd", 32'(buf_out_q));
      end
      tick();
      chk("post_rst_len", 32'(buf_out_len), 32'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
